borrow_div_seq: RTL and testbench

//   Multi-cycle unsigned restoring divider; the subtract/borrow counterpart of the

---
 rtl/borrow_div_seq_if.sv | 22 ++
 rtl/borrow_div_seq.sv | 133 +++++++++++++
 tb/tb_borrow_div_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/borrow_div_seq_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// master drives requests (ALU side); slave is the divider.
interface borrow_div_seq_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/borrow_div_seq.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle via a trial
// subtract built from generate/propagate carry cells (carry-out 1 = no borrow).
//
// state  | meaning
// S_IDLE | waiting for start; results held
// S_RUN  | iterating (cnt < WIDTH) or finishing (cnt == WIDTH)
// S_DONE | results valid, done pulse; start accepted back-to-back
module borrow_div_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  borrow_div_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH:0]   trial_g;
  logic [WIDTH:0]   trial_p;
  logic [WIDTH-1:0] trial_t;
  logic             no_borrow;

  // The partial remainder is WIDTH+1 bits wide only during the trial: its top bit
  // is the bit shifted out of r_q, and a kept remainder always fits in WIDTH bits.
  always_comb begin
    logic c;
    trial_a = {r_q, q_q[WIDTH-1]};
    trial_b = ~{1'b0, d_q};
    trial_g = trial_a & trial_b;
    trial_p = trial_a ^ trial_b;
    trial_t = '0;
    c       = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      trial_t[i] = trial_p[i] ^ c;
      c          = trial_g[i] | (trial_p[i] & c);
    end
    no_borrow = trial_g[WIDTH] | (trial_p[WIDTH] & c);
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          state_d = S_RUN;
          q_d     = bus.dividend;
          r_d     = '0;
          d_d     = bus.divisor;
          dz_d    = 1'b0;
          zero_d  = (bus.divisor == '0);
          // a zero divisor skips the iterations and finishes on the next edge
          cnt_d   = zero_d ? CW'(WIDTH) : '0;
        end
      end
      S_RUN: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d = S_DONE;
          quot_d  = zero_q ? '1 : q_q;
          rem_d   = zero_q ? q_q : r_q;
          dz_d    = zero_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (no_borrow) begin
            r_d = trial_t;
            q_d = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            r_d = trial_a[WIDTH-1:0];
            q_d = {q_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.div_by_zero = dz_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;

endmodule

// File: tb/tb_borrow_div_seq.sv
// Self-checking bench for borrow_div_seq: directed cases, an ignored mid-run start,
// a mid-run reset and random operand pairs against an arithmetic model.
module tb_borrow_div_seq;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  borrow_div_seq_if #(.WIDTH(WIDTH)) bus ();
  borrow_div_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Behavioural model: a request finishes a fixed number of edges after it is
  // accepted, with results from plain integer division.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mph_t;
  mph_t             m_ph = M_IDLE;
  int               m_left = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;
  logic             m_dz = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph <= M_IDLE; m_q <= '0; m_r <= '0; m_dz <= 1'b0; m_left <= 0;
    end else if (m_ph != M_RUN) begin
      if (bus.start) begin
        m_ph   <= M_RUN;
        m_a    <= bus.dividend;
        m_b    <= bus.divisor;
        m_dz   <= 1'b0;
        m_left <= (bus.divisor == 0) ? 1 : WIDTH + 1;
      end else begin
        m_ph <= M_IDLE;
      end
    end else if (m_left == 1) begin
      m_ph <= M_DONE;
      if (m_b == 0) begin
        m_q <= '1; m_r <= m_a; m_dz <= 1'b1;
      end else begin
        m_q <= m_a / m_b; m_r <= m_a % m_b;
      end
    end else begin
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", bus.busy, m_ph == M_RUN);
      check("done", bus.done, m_ph == M_DONE);
      check("div_by_zero", bus.div_by_zero, m_dz);
      check("quotient", bus.quotient, m_q);
      check("remainder", bus.remainder, m_r);
    end
  end

  // call at a negedge; returns just after the accepting edge
  task automatic pulse_start(input int a, input int b);
    bus.start    = 1'b1;
    bus.dividend = WIDTH'(a);
    bus.divisor  = WIDTH'(b);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // counts edges until done is seen; returns at the negedge where done is high
  task automatic wait_done(output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic run_div(input int a, input int b, input int eq, input int er,
                         input int elat, input int edz, input string tag);
    int lat;
    pulse_start(a, b);
    wait_done(lat);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    check({tag, "_dz"}, bus.div_by_zero, edz);
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dz", bus.div_by_zero, 0);
    check("rst_q", bus.quotient, 0);
    check("rst_r", bus.remainder, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    run_div(100, 7, 14, 2, 17, 0, "d100_7");
    @(negedge clk);
    run_div(16'hFFFF, 1, 16'hFFFF, 0, 17, 0, "dffff_1");
    run_div(16'hFFFF, 16'hFFFF, 1, 0, 17, 0, "dffff_ffff");
    run_div(5, 9, 0, 5, 17, 0, "d5_9");
    run_div(0, 3, 0, 0, 17, 0, "d0_3");
    @(negedge clk);
    run_div(1234, 0, 16'hFFFF, 1234, 1, 1, "d1234_0");
    @(negedge clk);

    // start during RUN is ignored, then a back-to-back start from DONE
    pulse_start(100, 7);
    repeat (4) @(negedge clk);
    pulse_start(50, 5);
    wait_done(lat);
    check("ign_latency", lat, 13);
    check("ign_q", bus.quotient, 14);
    check("ign_r", bus.remainder, 2);
    run_div(50, 5, 10, 0, 17, 0, "b2b_50_5");
    @(negedge clk);

    // reset part-way through a run
    pulse_start(100, 7);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_q", bus.quotient, 0);
    check("mid_rst_r", bus.remainder, 0);
    rst = 1'b0;
    @(negedge clk);
    run_div(200, 10, 20, 0, 17, 0, "after_rst");

    for (int i = 0; i < 2000; i++) begin
      int a, b, sel;
      a   = int'($urandom_range(0, 65535));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      b = 0;
      else if (sel < 4)  b = int'($urandom_range(1, 15));
      else if (sel < 6)  b = int'($urandom_range(1, 65535)) % (a + 1) + 1;
      else               b = int'($urandom_range(1, 65535));
      if (b > 65535) b = 65535;
      pulse_start(a, b);
      wait_done(lat);
      if (b == 0) begin
        check("rnd_dz", bus.div_by_zero, 1);
        check("rnd_dz_r", bus.remainder, a);
      end else begin
        check("rnd_inv_eq", longint'(bus.quotient) * b + bus.remainder, a);
        check("rnd_inv_lt", (bus.remainder < b) ? 1 : 0, 1);
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
